tff_pulse_seq: RTL and testbench



---
 rtl/tff_pulse_seq.sv | 109 ++++++++++
 tb/tb_tff_pulse_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_pulse_seq.sv
// Toggle-pulse sequencer: emits a programmed train of one-cycle t_out pulses,
// spaced by a programmable idle gap, then strobes done.
module tff_pulse_seq #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [GAP_W-1:0] gap_in,
  input  logic             abort,
  output logic             t_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] left_q, left_nxt;
  logic [GAP_W-1:0] gap_reg, gap_reg_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;

  // NOTE: every signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    left_nxt    = left_q;
    gap_reg_nxt = gap_reg;
    gap_cnt_nxt = gap_cnt;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (cnt_in != '0) begin
            left_nxt    = cnt_in;
            gap_reg_nxt = gap_in;
            state_nxt   = PULSE;
          end else begin
            state_nxt   = DONE;
          end
        end
      end

      PULSE: begin
        // PULSE is only entered with left_q >= 1, so this never underflows.
        left_nxt = left_q - CNT_W'(1);
        if (left_q == CNT_W'(1)) begin
          state_nxt = DONE;
        end else if (gap_reg == '0) begin
          state_nxt = PULSE;
        end else begin
          gap_cnt_nxt = gap_reg;
          state_nxt   = GAP;
        end
      end

      GAP: begin
        gap_cnt_nxt = gap_cnt - GAP_W'(1);
        if (gap_cnt == GAP_W'(1)) begin
          state_nxt = PULSE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort overrides every transition out of an active state.
    if (abort && (state != IDLE)) begin
      state_nxt   = IDLE;
      left_nxt    = '0;
      gap_cnt_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      left_q  <= '0;
      gap_reg <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      left_q  <= left_nxt;
      gap_reg <= gap_reg_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Outputs decode the state register only; no input reaches them combinationally.
  assign t_out       = (state == PULSE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign pulses_left = left_q;

endmodule

// File: tb/tb_tff_pulse_seq.sv
// Self-checking bench for tff_pulse_seq: a schedule-based train model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_tff_pulse_seq;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] cnt_in;
  logic [GAP_W-1:0] gap_in;
  logic             abort;
  logic             t_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_left;

  int n_vec = 0;
  int n_bad = 0;

  tff_pulse_seq #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cnt_in      (cnt_in),
    .gap_in      (gap_in),
    .abort       (abort),
    .t_out       (t_out),
    .busy        (busy),
    .done        (done),
    .pulses_left (pulses_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream two-stage chain: stage 0 toggles on t_out, stage 1 follows stage 0.
  logic q0, q1, chain_clr;
  always @(posedge clk) begin
    if (chain_clr) begin
      q0 <= 1'b0;
      q1 <= 1'b0;
    end else begin
      q0 <= q0 ^ t_out;
      q1 <= q0;
    end
  end

  // Train model: k is the cycle index within an accepted train (1 = first cycle after start).
  bit m_valid  = 1'b0;
  bit m_active = 1'b0;
  int m_k, m_n, m_g, m_done_k;

  function automatic int pulses_before(input int k, input int n, input int g);
    int p;
    if (n == 0 || k < 2) return 0;
    p = (k - 2) / (g + 1) + 1;
    return (p > n) ? n : p;
  endfunction

  always @(negedge clk) begin
    int exp_t, exp_b, exp_d, exp_pl;
    if (m_valid) begin
      if (m_active) begin
        exp_t  = (m_n > 0 && ((m_k - 1) % (m_g + 1)) == 0 && ((m_k - 1) / (m_g + 1)) < m_n) ? 1 : 0;
        exp_b  = 1;
        exp_d  = (m_k == m_done_k) ? 1 : 0;
        exp_pl = m_n - pulses_before(m_k, m_n, m_g);
      end else begin
        exp_t  = 0;
        exp_b  = 0;
        exp_d  = 0;
        exp_pl = 0;
      end
      check("model_t_out", t_out, exp_t);
      check("model_busy", busy, exp_b);
      check("model_done", done, exp_d);
      check("model_pulses_left", pulses_left, exp_pl);
    end
    if (rst) begin
      m_active = 1'b0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      if (m_active) begin
        if (abort || m_k == m_done_k) m_active = 1'b0;
        else m_k++;
      end else if (start) begin
        m_active = 1'b1;
        m_k      = 1;
        m_n      = int'(cnt_in);
        m_g      = int'(gap_in);
        m_done_k = (m_n == 0) ? 1 : 2 + (m_n - 1) * (m_g + 1);
      end
    end
  end

  task automatic start_train(input int n, input int g);
    start  = 1'b1;
    cnt_in = CNT_W'(n);
    gap_in = GAP_W'(g);
    tick();
    start  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pcount;
    int done_at;
    rst = 1'b1; start = 1'b1; cnt_in = 8'd5; gap_in = '0; abort = 1'b0; chain_clr = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_t_out", t_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pulses_left", pulses_left, 0);
    rst = 1'b0; start = 1'b0; chain_clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_idle", t_out | busy, 0);
      tick();
    end

    // Basic train: 3 pulses, gap 2.
    start_train(3, 2);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("basic_t_out", t_out, (c == 1 || c == 4 || c == 7));
      check("basic_done", done, (c == 8));
      check("basic_busy", busy, (c <= 8));
      if (c == 1) check("basic_left_c1", pulses_left, 3);
      if (c == 2) check("basic_left_c2", pulses_left, 2);
      if (c == 5) check("basic_left_c5", pulses_left, 1);
      if (c == 8) check("basic_left_c8", pulses_left, 0);
      tick();
    end

    // Back-to-back: 4 pulses, no gap, into a cleared chain.
    chain_clr = 1'b1;
    tick();
    chain_clr = 1'b0;
    start_train(4, 0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check("b2b_t_out", t_out, (c <= 4));
      check("b2b_done", done, (c == 5));
      if (c == 6) begin
        check("b2b_chain_q0", q0, 0);
        check("b2b_chain_q1", q1, 0);
      end
      tick();
    end

    // Zero count.
    start_train(0, 3);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("zero_t_out", t_out, 0);
      check("zero_done", done, (c == 1));
      check("zero_busy", busy, (c == 1));
      tick();
    end

    // Abort in IDLE does nothing.
    abort = 1'b1;
    tick();
    @(negedge clk);
    check("idle_abort_busy", busy, 0);
    abort = 1'b0;
    tick();

    // Ignored restart, then abort in GAP.
    start_train(10, 1);
    for (int c = 1; c <= 8; c++) begin
      start = (c == 2);
      if (c == 2) cnt_in = 8'd1;
      abort = (c == 4);
      @(negedge clk);
      check("abort_t_out", t_out, (c == 1 || c == 3));
      check("abort_busy", busy, (c <= 4));
      check("abort_done", done, 0);
      if (c == 4) check("abort_left_c4", pulses_left, 8);
      if (c >= 5) check("abort_left_idle", pulses_left, 0);
      tick();
    end
    start = 1'b0; abort = 1'b0;

    // Abort in PULSE.
    start_train(5, 3);
    for (int c = 1; c <= 3; c++) begin
      abort = (c == 1);
      @(negedge clk);
      check("abort_pulse_busy", busy, (c == 1));
      check("abort_pulse_left", pulses_left, (c == 1) ? 5 : 0);
      tick();
    end
    abort = 1'b0;

    // Abort in DONE: the visible done stands.
    start_train(1, 0);
    for (int c = 1; c <= 3; c++) begin
      abort = (c == 2);
      @(negedge clk);
      check("abort_done_strobe", done, (c == 2));
      check("abort_done_busy", busy, (c <= 2));
      tick();
    end
    abort = 1'b0;

    // Start while DONE is showing is ignored.
    start_train(2, 0);
    for (int c = 1; c <= 5; c++) begin
      start = (c == 3);
      @(negedge clk);
      check("done_start_t_out", t_out, (c <= 2));
      check("done_start_busy", busy, (c <= 3));
      tick();
    end
    start = 1'b0;

    // Limits with reset in cycle 100.
    start_train(255, 15);
    for (int c = 1; c <= 110; c++) begin
      rst = (c == 100);
      @(negedge clk);
      check("limit_t_out", t_out, (c <= 100 && ((c - 1) % 16) == 0));
      if (c == 1) check("limit_left_c1", pulses_left, 255);
      if (c == 18) check("limit_left_c18", pulses_left, 253);
      if (c == 101) begin
        check("midrst_busy", busy, 0);
        check("midrst_left", pulses_left, 0);
      end
      tick();
    end
    rst = 1'b0;

    // Full-length maximum train.
    start_train(255, 15);
    pcount  = 0;
    done_at = 0;
    for (int c = 1; c <= 4070; c++) begin
      @(negedge clk);
      if (t_out) pcount++;
      if (done) done_at = c;
      tick();
    end
    check("max_pulse_count", pcount, 255);
    check("max_done_cycle", done_at, 4066);
    check("max_idle_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
